// File: rtl/vx_flush_ctrl.sv
// vx_flush_ctrl: walks every line of one cache bank's tag store to invalidate it,
//   either on explicit request or (optionally) right after reset, and otherwise
//   passes fill requests straight through to the tag store.
// Latency: fills are accepted combinationally in the cycle they are presented (IDLE only);
//   a flush walk takes LINES_PER_BANK unstalled cycles plus one DONE cycle.
// Backpressure: stall freezes the walk and blocks fills; outside IDLE both request
//   inputs see ready = 0 and must be held by the requester.
//
// Ports:
//   clk, reset                    sole clock, synchronous active-high reset
//   stall                         tag pipeline stall
//   flush_req_valid/_ready        whole-bank invalidate request handshake
//   flush_done                    one-cycle pulse when a requested flush finishes
//   fill_valid/fill_addr/_ready   line fill handshake from the memory response path
//   tag_addr/tag_fill/tag_flush   tag store command (address + fill or invalidate strobe)
//   busy                          controller is walking or finishing a walk
//
// Build option: define VX_FLUSH_ON_RESET_EN to invalidate every line after reset
// before any fill or flush request is accepted.

module vx_flush_ctrl #(
   parameter int CACHE_ID        = 0,
   parameter int BANK_ID         = 0,
   parameter int LINES_PER_BANK  = 64,
   parameter int LINE_ADDR_WIDTH = 26
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       stall,
   input  logic                       flush_req_valid,
   output logic                       flush_req_ready,
   output logic                       flush_done,
   input  logic                       fill_valid,
   input  logic [LINE_ADDR_WIDTH-1:0] fill_addr,
   output logic                       fill_ready,
   output logic [LINE_ADDR_WIDTH-1:0] tag_addr,
   output logic                       tag_fill,
   output logic                       tag_flush,
   output logic                       busy
);

   localparam int LSB = $clog2(LINES_PER_BANK);

   // Configuration sanity: the walk counter wraps naturally only for power-of-two sizes.
   if (LINES_PER_BANK < 2 || (LINES_PER_BANK & (LINES_PER_BANK - 1)) != 0 ||
       LINE_ADDR_WIDTH < LSB || CACHE_ID < 0 || BANK_ID < 0) begin : g_bad_cfg
      $error("vx_flush_ctrl: illegal parameter set");
   end

   typedef enum logic [1:0] {
      S_INIT  = 2'd0,
      S_IDLE  = 2'd1,
      S_FLUSH = 2'd2,
      S_DONE  = 2'd3
   } state_t;

`ifdef VX_FLUSH_ON_RESET_EN
   localparam state_t RESET_STATE = S_INIT;
`else
   localparam state_t RESET_STATE = S_IDLE;
`endif

   localparam logic [LSB-1:0] CNT_ONE  = LSB'(1);
   localparam logic [LSB-1:0] CNT_LAST = LSB'(LINES_PER_BANK - 1);

   state_t         state, state_nxt;
   logic [LSB-1:0] counter, counter_nxt;

   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= RESET_STATE;
         counter <= '0;
      end else begin
         state   <= state_nxt;
         counter <= counter_nxt;
      end
   end

   always_comb begin
      state_nxt       = state;
      counter_nxt     = counter;
      flush_req_ready = 1'b0;
      flush_done      = 1'b0;
      fill_ready      = 1'b0;
      tag_fill        = 1'b0;
      tag_flush       = 1'b0;
      tag_addr        = '0;
      busy            = 1'b1;

      case (state)
         S_IDLE: begin
            busy            = 1'b0;
            flush_req_ready = 1'b1;
            // A same-cycle flush request wins; the fill stays pending until we return.
            fill_ready      = fill_valid && !stall && !flush_req_valid;
            tag_fill        = fill_ready;
            if (fill_ready) begin
               tag_addr = fill_addr;
            end
            if (flush_req_valid) begin
               state_nxt   = S_FLUSH;
               counter_nxt = '0;
            end
         end

`ifdef VX_FLUSH_ON_RESET_EN
         S_INIT, S_FLUSH: begin
`else
         S_FLUSH: begin
`endif
            // Stalled cycles re-drive the same line; invalidating twice is harmless.
            tag_flush = 1'b1;
            tag_addr  = LINE_ADDR_WIDTH'(counter);
            if (!stall) begin
               counter_nxt = counter + CNT_ONE;   // wraps to 0 after the last line
               if (counter == CNT_LAST) begin
                  state_nxt = (state == S_FLUSH) ? S_DONE : S_IDLE;
               end
            end
         end

         S_DONE: begin
            flush_done = 1'b1;
            state_nxt  = S_IDLE;
         end

         default: begin
            state_nxt = S_IDLE;
         end
      endcase

      // Keep every handshake and strobe quiet while reset is held, whatever the state.
      if (reset) begin
         flush_req_ready = 1'b0;
         flush_done      = 1'b0;
         fill_ready      = 1'b0;
         tag_fill        = 1'b0;
         tag_flush       = 1'b0;
         tag_addr        = '0;
      end
   end

endmodule

// File: tb/tb_vx_flush_ctrl.sv
// tb_vx_flush_ctrl: directed bench for vx_flush_ctrl with LINES_PER_BANK=4, LINE_ADDR_WIDTH=8.
// Inputs change on the falling edge; outputs are sampled 1 time unit later.
// Works with or without VX_FLUSH_ON_RESET_EN defined.

module tb_vx_flush_ctrl;

   localparam int LPB = 4;
   localparam int AW  = 8;

   logic          clk = 1'b0;
   logic          reset;
   logic          stall;
   logic          flush_req_valid;
   logic          flush_req_ready;
   logic          flush_done;
   logic          fill_valid;
   logic [AW-1:0] fill_addr;
   logic          fill_ready;
   logic [AW-1:0] tag_addr;
   logic          tag_fill;
   logic          tag_flush;
   logic          busy;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   vx_flush_ctrl #(
      .CACHE_ID        (0),
      .BANK_ID         (0),
      .LINES_PER_BANK  (LPB),
      .LINE_ADDR_WIDTH (AW)
   ) dut (
      .clk             (clk),
      .reset           (reset),
      .stall           (stall),
      .flush_req_valid (flush_req_valid),
      .flush_req_ready (flush_req_ready),
      .flush_done      (flush_done),
      .fill_valid      (fill_valid),
      .fill_addr       (fill_addr),
      .fill_ready      (fill_ready),
      .tag_addr        (tag_addr),
      .tag_fill        (tag_fill),
      .tag_flush       (tag_flush),
      .busy            (busy)
   );

   task automatic chk1(input string tag, input logic obs, input logic exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   task automatic chk8(input string tag, input logic [AW-1:0] obs, input logic [AW-1:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // One walk cycle: invalidate strobe on the expected line, everything else held off.
   task automatic walk_line(input string tag, input logic [AW-1:0] line);
      #1;
      chk1({tag, "_tag_flush"},  tag_flush,       1'b1);
      chk8({tag, "_tag_addr"},   tag_addr,        line);
      chk1({tag, "_tag_fill"},   tag_fill,        1'b0);
      chk1({tag, "_fill_rdy"},   fill_ready,      1'b0);
      chk1({tag, "_flush_rdy"},  flush_req_ready, 1'b0);
      chk1({tag, "_busy"},       busy,            1'b1);
      chk1({tag, "_flush_done"}, flush_done,      1'b0);
      @(negedge clk);
   endtask

   initial begin
      reset           = 1'b1;
      stall           = 1'b0;
      flush_req_valid = 1'b0;
      fill_valid      = 1'b1;
      fill_addr       = 8'h11;

      // Reset held: all handshakes and strobes quiet even with a fill pending.
      @(negedge clk);
      @(negedge clk);
      #1;
      chk1("rst_fill_ready", fill_ready,      1'b0);
      chk1("rst_tag_fill",   tag_fill,        1'b0);
      chk1("rst_tag_flush",  tag_flush,       1'b0);
      chk1("rst_flush_done", flush_done,      1'b0);
      chk1("rst_flush_rdy",  flush_req_ready, 1'b0);
      chk8("rst_tag_addr",   tag_addr,        8'h00);
      @(negedge clk);
      reset = 1'b0;

`ifdef VX_FLUSH_ON_RESET_EN
      // Init walk over lines 0..3 while the fill is held off.
      for (int i = 0; i < LPB; i++) walk_line("init", 8'(i));
`endif
      // First IDLE cycle: pending fill goes through, no completion pulse.
      #1;
      chk1("post_rst_busy",       busy,       1'b0);
      chk1("post_rst_tag_flush",  tag_flush,  1'b0);
      chk1("post_rst_flush_done", flush_done, 1'b0);
      chk1("post_rst_fill_rdy",   fill_ready, 1'b1);
      chk8("post_rst_tag_addr",   tag_addr,   8'h11);
      @(negedge clk);

      // Fill pass-through, then blocked by stall.
      fill_addr = 8'h5A;
      #1;
      chk1("fill_rdy",      fill_ready, 1'b1);
      chk1("fill_tag_fill", tag_fill,   1'b1);
      chk8("fill_tag_addr", tag_addr,   8'h5A);
      stall = 1'b1;
      #1;
      chk1("fill_stall_rdy",  fill_ready, 1'b0);
      chk1("fill_stall_tagf", tag_fill,   1'b0);
      chk8("fill_stall_addr", tag_addr,   8'h00);
      stall      = 1'b0;
      fill_valid = 1'b0;
      #1;
      chk1("idle_flush_rdy", flush_req_ready, 1'b1);
      chk8("idle_tag_addr",  tag_addr,        8'h00);
      @(negedge clk);

      // Requested flush with one stall on the second walk cycle: 0,1,1,2,3 then DONE.
      flush_req_valid = 1'b1;
      #1;
      chk1("flreq_rdy", flush_req_ready, 1'b1);
      @(negedge clk);
      flush_req_valid = 1'b0;
      walk_line("fl", 8'h00);
      stall = 1'b1;
      walk_line("fl_stall", 8'h01);
      stall = 1'b0;
      walk_line("fl", 8'h01);
      walk_line("fl", 8'h02);
      walk_line("fl", 8'h03);
      #1;
      chk1("done_pulse",     flush_done, 1'b1);
      chk1("done_tag_flush", tag_flush,  1'b0);
      chk1("done_tag_fill",  tag_fill,   1'b0);
      chk1("done_busy",      busy,       1'b1);
      chk8("done_tag_addr",  tag_addr,   8'h00);
      @(negedge clk);
      #1;
      chk1("after_done_pulse", flush_done, 1'b0);
      chk1("after_done_busy",  busy,       1'b0);
      @(negedge clk);

      // Same-cycle fill and flush: flush wins, fill waits for the first IDLE cycle.
      fill_valid      = 1'b1;
      fill_addr       = 8'h33;
      flush_req_valid = 1'b1;
      #1;
      chk1("conf_flush_rdy", flush_req_ready, 1'b1);
      chk1("conf_fill_rdy",  fill_ready,      1'b0);
      chk1("conf_tag_fill",  tag_fill,        1'b0);
      @(negedge clk);
      flush_req_valid = 1'b0;
      for (int i = 0; i < LPB; i++) walk_line("conf", 8'(i));
      #1;
      chk1("conf_done",          flush_done, 1'b1);
      chk1("conf_done_fill_rdy", fill_ready, 1'b0);
      @(negedge clk);
      #1;
      chk1("conf_fill_back", fill_ready, 1'b1);
      chk1("conf_tagf_back", tag_fill,   1'b1);
      chk8("conf_addr_back", tag_addr,   8'h33);
      chk1("conf_no_pulse",  flush_done, 1'b0);
      fill_valid = 1'b0;
      @(negedge clk);

      // Reset in the middle of a walk, at line 2.
      flush_req_valid = 1'b1;
      @(negedge clk);
      flush_req_valid = 1'b0;
      walk_line("abort", 8'h00);
      walk_line("abort", 8'h01);
      #1;
      chk8("abort_line2", tag_addr, 8'h02);
      reset = 1'b1;
      #1;
      chk1("abort_rst_tag_flush", tag_flush,  1'b0);
      chk1("abort_rst_done",      flush_done, 1'b0);
      chk8("abort_rst_tag_addr",  tag_addr,   8'h00);
      @(negedge clk);
      reset = 1'b0;
`ifdef VX_FLUSH_ON_RESET_EN
      for (int i = 0; i < LPB; i++) walk_line("rewalk", 8'(i));
      #1;
      chk1("rewalk_busy",      busy,       1'b0);
      chk1("rewalk_tag_flush", tag_flush,  1'b0);
      chk1("rewalk_no_done",   flush_done, 1'b0);
`else
      #1;
      chk1("abort_idle_busy",      busy,      1'b0);
      chk1("abort_idle_tag_flush", tag_flush, 1'b0);
      for (int i = 0; i < LPB + 1; i++) begin
         chk1("abort_no_done", flush_done, 1'b0);
         @(negedge clk);
         #1;
      end
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
